// File: rtl/bram_diff_stim.sv
// rtl/bram_diff_stim.sv - serial LFSR stimulus and readback signature generator for a BRAM harness
// Optional CRC-16 signature via BRAM_DIFF_STIM_MISR_EN; default is an 8-bit XOR signature.
module bram_diff_stim #(
  parameter logic [15:0] N_VEC = 16'd16,
  parameter logic [7:0]  SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dut_do,
  output logic        di,
  output logic        stb,
  output logic        busy,
  output logic        done,
  output logic [15:0] sig
);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_STROBE, S_DRAIN, S_FIN} state_t;

`ifdef BRAM_DIFF_STIM_MISR_EN
  localparam logic [15:0] SIG_INIT = 16'hFFFF;

  function automatic logic [15:0] sig_fold(input logic [15:0] s, input logic [7:0] b);
    logic [15:0] c;
    c = s;
    for (int i = 7; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ (((c[15] ^ b[i]) == 1'b1) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
`else
  localparam logic [15:0] SIG_INIT = 16'h0000;

  // Upper byte is always zero in this mode, so a full-width XOR keeps it zero.
  function automatic logic [15:0] sig_fold(input logic [15:0] s, input logic [7:0] b);
    return s ^ {8'h00, b};
  endfunction
`endif

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  cap_q, cap_d;
  logic [15:0] sig_q, sig_d;
  logic [16:0] frame_inc;
  logic [7:0]  cap_byte;
  logic        capture;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    cap_d     = cap_q;
    sig_d     = sig_q;
    di        = 1'b0;
    stb       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    frame_inc = {1'b0, frame_q} + 17'd1;
    cap_byte  = {cap_q[6:0], dut_do};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sig_d   = SIG_INIT;
          lfsr_d  = SEED;
          frame_d = 16'd0;
          cap_d   = 8'd0;
          // An empty run still spends one busy cycle: a one-cycle DRAIN with capture disabled.
          if (N_VEC == 16'd0) begin
            state_d = S_DRAIN;
            bit_d   = 3'd7;
          end else begin
            state_d = S_SHIFT;
            bit_d   = 3'd0;
          end
        end
      end
      S_SHIFT: begin
        busy    = 1'b1;
        di      = lfsr_q[~bit_q];
        capture = (frame_q != 16'd0);
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        busy    = 1'b1;
        stb     = 1'b1;
        lfsr_d  = {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? 8'h71 : 8'h00);
        frame_d = frame_inc[15:0];
        bit_d   = 3'd0;
        state_d = (frame_inc == {1'b0, N_VEC}) ? S_DRAIN : S_SHIFT;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        capture = (N_VEC != 16'd0);
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Readback lags the stimulus by one frame; the byte is folded on its eighth bit.
    if (capture) begin
      cap_d = cap_byte;
      if (bit_q == 3'd7) begin
        sig_d = sig_fold(sig_q, cap_byte);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      bit_q   <= 3'd0;
      frame_q <= 16'd0;
      cap_q   <= 8'd0;
      sig_q   <= SIG_INIT;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      cap_q   <= cap_d;
      sig_q   <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: tb/tb_bram_diff_stim.sv
// tb/tb_bram_diff_stim.sv - self-checking bench for bram_diff_stim over several N_VEC instances
`timescale 1ns/1ps
module tb_bram_diff_stim;
  localparam int NI = 6;
  localparam logic [95:0] NV_PACK = {16'd16, 16'd8, 16'd4, 16'd3, 16'd1, 16'd0};
  localparam logic [7:0] SEED = 8'hA5;
`ifdef BRAM_DIFF_STIM_MISR_EN
  localparam logic [15:0] SIG_INIT = 16'hFFFF;
  localparam logic [15:0] SIG_ONE_ZERO = 16'hE1F0;
`else
  localparam logic [15:0] SIG_INIT = 16'h0000;
  localparam logic [15:0] SIG_ONE_ZERO = 16'h0000;
`endif
  localparam int HL = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic dut_do = 1'b0;
  logic [NI-1:0] di_v, stb_v, busy_v, done_v;
  logic [15:0] sig_v [NI];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      bram_diff_stim #(.N_VEC(NV_PACK[g*16 +: 16]), .SEED(SEED)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_do(dut_do),
        .di(di_v[g]), .stb(stb_v[g]), .busy(busy_v[g]), .done(done_v[g]), .sig(sig_v[g])
      );
    end
  endgenerate

  typedef struct {
    logic        val;
    int          idx;
    int          exp_busy;
    int          exp_stb;
    int          exp_done;
    logic [15:0] exp_sig;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] sig;
  } sb_t;

  vec_t tbl [12];
  sb_t  sb_q [$];
  logic stream_b [0:HL-1];
  logic [NI-1:0] di_h [0:HL-1];
  logic [NI-1:0] stb_h [0:HL-1];
  logic [NI-1:0] busy_h [0:HL-1];
  logic [NI-1:0] done_h [0:HL-1];
  int n_checks = 0;
  int n_fail = 0;

  function automatic int nv(input int i);
    return int'(NV_PACK[i*16 +: 16]);
  endfunction

  // Byte j of readback is driven in cycles 9j+1..9j+8 after the start edge, MSB first.
  function automatic logic [15:0] model_sig(input int n);
    logic [15:0] s;
    logic b;
    s = SIG_INIT;
    for (int j = 1; j <= n; j++) begin
      for (int i = 0; i < 8; i++) begin
        b = stream_b[9*j + 1 + i];
`ifdef BRAM_DIFF_STIM_MISR_EN
        if ((s[15] ^ b) == 1'b1) s = {s[14:0], 1'b0} ^ 16'h1021;
        else s = {s[14:0], 1'b0};
`else
        s[7-i] = s[7-i] ^ b;
`endif
      end
    end
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_stream(input int mode);
    for (int k = 0; k < HL; k++) begin
      stream_b[k] = (mode == 2) ? logic'($urandom_range(0, 1)) : logic'(mode);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Entered #1 after a posedge; cycle k is the interval after the k-th edge following the start edge.
  task automatic run(input int ncyc, input bit hold, input bit sb_on);
    sb_t e;
    start = 1'b1;
    dut_do = stream_b[0];
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int k = 1; k < ncyc; k++) begin
      dut_do = stream_b[k];
      di_h[k] = di_v;
      stb_h[k] = stb_v;
      busy_h[k] = busy_v;
      done_h[k] = done_v;
      if (sb_on) begin
        for (int gi = 0; gi < NI; gi++) begin
          if (done_v[gi]) begin
            if (sb_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL sb_empty: done on instance %0d with no expected entry", gi);
            end else begin
              e = sb_q.pop_front();
              chk("sb_idx", gi, e.idx);
              chk("sb_sig", int'(sig_v[gi]), int'(e.sig));
            end
          end
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic stats(input int gi, input int ncyc, output int nb, output int ns, output int dc);
    nb = 0;
    ns = 0;
    dc = 0;
    for (int k = 1; k < ncyc; k++) begin
      if (busy_h[k][gi]) nb++;
      if (stb_h[k][gi]) ns++;
      if (done_h[k][gi] && dc == 0) dc = k;
    end
  endtask

  function automatic logic [7:0] di_byte(input int gi, input int first);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7-i] = di_h[first + i][gi];
    return v;
  endfunction

  initial begin
    int nb, ns, dc, nd;
    logic [7:0] m;
    logic carry;

    for (int p = 0; p < 2; p++) begin
      fill_stream(1 - p);
      for (int gi = 0; gi < NI; gi++) begin
        tbl[p*NI + gi].val = logic'(1 - p);
        tbl[p*NI + gi].idx = gi;
        tbl[p*NI + gi].exp_busy = (nv(gi) == 0) ? 1 : 9*nv(gi) + 8;
        tbl[p*NI + gi].exp_stb = nv(gi);
        tbl[p*NI + gi].exp_done = tbl[p*NI + gi].exp_busy + 1;
        tbl[p*NI + gi].exp_sig = model_sig(nv(gi));
      end
    end

    #2;
    chk("rst_di", int'(di_v), 0);
    chk("rst_stb", int'(stb_v), 0);
    chk("rst_busy", int'(busy_v), 0);
    chk("rst_done", int'(done_v), 0);
    for (int gi = 0; gi < NI; gi++) chk("rst_sig", int'(sig_v[gi]), int'(SIG_INIT));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int p = 0; p < 2; p++) begin
      fill_stream(1 - p);
      do_reset();
      run(170, 1'b0, 1'b0);
      for (int r = 0; r < 12; r++) begin
        if (tbl[r].val == logic'(1 - p)) begin
          stats(tbl[r].idx, 170, nb, ns, dc);
          chk($sformatf("tbl%0d_busy", r), nb, tbl[r].exp_busy);
          chk($sformatf("tbl%0d_stb", r), ns, tbl[r].exp_stb);
          chk($sformatf("tbl%0d_done", r), dc, tbl[r].exp_done);
          chk($sformatf("tbl%0d_sig", r), int'(sig_v[tbl[r].idx]), int'(tbl[r].exp_sig));
        end
      end
      if (p == 1) chk("n1_zero_sig", int'(sig_v[1]), int'(SIG_ONE_ZERO));
    end

    fill_stream(2);
    do_reset();
    for (int gi = 0; gi < NI; gi++) sb_q.push_back('{idx: gi, sig: model_sig(nv(gi))});
    run(170, 1'b0, 1'b1);
    chk("sb_left", sb_q.size(), 0);
    chk("n1_stb_c9", int'(stb_h[9][1]), 1);
    chk("n1_di_f0", int'(di_byte(1, 1)), int'(SEED));
    m = SEED;
    for (int f = 0; f < 16; f++) begin
      chk($sformatf("n16_di_f%0d", f), int'(di_byte(5, 9*f + 1)), int'(m));
      carry = m[7];
      m = m << 1;
      if (carry) m = m ^ 8'h71;
    end

    fill_stream(0);
    do_reset();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("mid_busy_pre", int'(busy_v[4]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", int'(busy_v), 0);
    chk("mid_di", int'(di_v), 0);
    chk("mid_stb", int'(stb_v), 0);
    chk("mid_done", int'(done_v), 0);
    chk("mid_sig", int'(sig_v[4]), int'(SIG_INIT));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk);
      #1;
      if (done_v != '0 || busy_v != '0) nd++;
    end
    chk("mid_no_done", nd, 0);
    run(30, 1'b0, 1'b0);
    chk("mid_restart_busy", int'(busy_h[1][4]), 1);
    chk("mid_restart_di", int'(di_byte(4, 1)), int'(SEED));

    do_reset();
    run(100, 1'b1, 1'b0);
    nd = 0;
    for (int k = 1; k <= 95; k++) if (done_h[k][1]) nd++;
    chk("hold_done18", int'(done_h[18][1]), 1);
    chk("hold_idle19", int'(busy_h[19][1]), 0);
    chk("hold_busy20", int'(busy_h[20][1]), 1);
    chk("hold_runs", nd, 5);
    chk("hold_di_run2", int'(di_byte(1, 20)), int'(SEED));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_diff_stim.md
BRAM_DIFF_STIM -- requirements
Module: bram_diff_stim

Interface
REQ-001 Parameter N_VEC, default 16, number of 8-bit test vectors per run (16-bit, 0..65535).
REQ-002 Parameter SEED, default 8'hA5, nonzero LFSR start value; first vector of every run.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  run request, sampled only in IDLE.
REQ-006 dut_do  input  1  serial readback from the BRAM harness output shifter, MSB first.
REQ-007 di  output  1  serial data to the harness input shifter, MSB first.
REQ-008 stb  output  1  one-cycle load strobe to the harness.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  one-cycle pulse at run completion.
REQ-011 sig  output  16  signature of captured readback bytes, held after done.

Function
REQ-012 States: IDLE, SHIFT, STROBE, DRAIN, FIN; a frame is 8 SHIFT cycles plus 1 STROBE cycle.
REQ-013 IDLE with start=1 at an edge: next cycle enters SHIFT frame 0, busy=1, sig reinitialised, LFSR loaded with SEED.
REQ-014 SHIFT cycle i (0..7): di = vec[7-i], stb=0.
REQ-015 STROBE cycle: stb=1, di=0, LFSR advances once (x^8+x^6+x^5+x^4+1, Galois form, shift left).
REQ-016 Frames 0..N_VEC-1 each run SHIFT then STROBE; after the last STROBE, enter DRAIN for 8 cycles with di=0, stb=0.
REQ-017 Capture: in each of the 8 cycles after any STROBE (SHIFT of the next frame or DRAIN), sample dut_do at the closing edge into an 8-bit capture register, MSB first.
REQ-018 After the 8th capture bit, the complete byte updates sig in the same edge.
REQ-019 Exactly N_VEC bytes are captured per run; readback during frame 0 is not captured.
REQ-020 After the final DRAIN cycle: FIN for one cycle with done=1, busy=0; then IDLE.
REQ-021 Run length: busy high for exactly 9*N_VEC+8 cycles.
REQ-022 N_VEC=0: start leads directly to FIN (busy one cycle, no stb, done next cycle), sig = init value.
REQ-023 start while busy or in FIN: ignored, no queuing.
REQ-024 sig stable from the done cycle until the cycle after the next accepted start.

Reset
REQ-025 rst_n low forces IDLE immediately: di=0, stb=0, busy=0, done=0, sig=init value, capture register and frame counter cleared.
REQ-026 Reset mid-run abandons the run; no done pulse; a new start after release begins a fresh run from SEED.

Configuration
REQ-027 Macro BRAM_DIFF_STIM_MISR_EN defined: sig is CRC-16 (poly 0x1021, MSB-first byte feed, no reflection, no final XOR), init 16'hFFFF.
REQ-028 Macro undefined: sig = {8'h00, XOR of all captured bytes}, init 16'h0000; MISR logic absent.

Verification
REQ-029 SEED=8'hA5, N_VEC=1, start pulse -> di over cycles 1..8 after start edge = 1,0,1,0,0,1,0,1; stb=1 in cycle 9; busy high 17 cycles; done in cycle 18.
REQ-030 Macro undefined, N_VEC=3, dut_do tied 1 -> sig=16'h00FF at done; N_VEC=4 -> sig=16'h0000.
REQ-031 Macro defined, N_VEC=0 -> done 2 cycles after start edge, sig=16'hFFFF, stb never asserted.
REQ-032 Macro defined, dut_do tied 0, N_VEC=1 -> sig equals CRC-16/0x1021 of byte 8'h00 from 16'hFFFF (16'hE1F0); bench reference model matches for N_VEC=16 random dut_do.
REQ-033 rst_n pulsed low in frame 2 of N_VEC=8 -> outputs zero/idle asynchronously, no done; a following start yields di pattern beginning with SEED bits.
REQ-034 start held high through an entire run -> exactly one run per IDLE acceptance; second run begins the cycle after FIN returns to IDLE.
